mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 41 ++++
 rtl/mem_stage_align.sv | 45 ++++
 rtl/mem_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, bus layouts, size codes and FSM states for the MEM pipeline stage.
// The misalignment helper is only used when MEM_ALIGN_CHECK_EN is defined.
package mem_stage_pkg;

  localparam int RegW          = 32;
  localparam int RegAddrBusW   = 5;
  localparam int EX2MEMBusSize = 109;
  localparam int MEM2WBBusSize = 70;

  localparam logic [2:0] SizeByte = 3'b100;
  localparam logic [2:0] SizeHalf = 3'b010;
  localparam logic [2:0] SizeWord = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic       load;
    logic       store;
    logic       bh_sign;
    logic [2:0] size;
  } mem_ctl_t;

  typedef struct packed {
    logic                   multiply;
    mem_ctl_t               mem_ctl;
    logic [RegW-1:0]        st_data;
    logic [RegW-1:0]        exe_result;
    logic [RegAddrBusW-1:0] rd_addr;
    logic                   rd_we;
    logic [RegW-1:0]        pc;
  } ex2mem_t;

  function automatic logic misaligned(logic [2:0] size, logic [1:0] off);
    return ((size == SizeHalf) && off[0]) || ((size == SizeWord) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational data-path helper for the MEM stage: store strobes and lane
// replication, plus load lane extraction with sign/zero extension.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  size,
  input  logic        bh_sign,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[{off, 3'b000} +: 8];
  assign half_lane = rdata[{off[1], 4'b0000} +: 16];

  // Non-one-hot size codes produce no strobes so a cleared stage drives zeros.
  always_comb begin
    wstrb     = 4'b0000;
    wdata     = st_data;
    load_data = rdata;
    case (size)
      SizeByte: begin
        wstrb     = 4'b0001 << off;
        wdata     = {4{st_data[7:0]}};
        load_data = {{24{bh_sign & byte_lane[7]}}, byte_lane};
      end
      SizeHalf: begin
        wstrb     = 4'b0011 << off;
        wdata     = {2{st_data[15:0]}};
        load_data = {{16{bh_sign & half_lane[15]}}, half_lane};
      end
      SizeWord: begin
        wstrb     = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, runs its data-memory access or
// multiply write-back, and hands the result to WB. Option: MEM_ALIGN_CHECK_EN.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [EX2MEMBusSize-1:0] ex2mem_bus_i,
  input  logic                     ex_over_i,
  output logic                     mem_allowin_o,
  input  logic [63:0]              mult_product_i,
  output logic                     dram_req_o,
  output logic                     dram_we_o,
  output logic [31:0]              dram_addr_o,
  output logic [31:0]              dram_wdata_o,
  output logic [3:0]               dram_wstrb_o,
  input  logic                     dram_ack_i,
  input  logic [31:0]              dram_rdata_i,
  input  logic                     wb_allowin_i,
  output logic                     mem_over_o,
  output logic [MEM2WBBusSize-1:0] mem2wb_bus_o,
  output logic [31:0]              forward_mem2id_data_o,
  output logic                     forward_mem2id_valid_o,
  output logic [4:0]               ctl_mem_dest_o,
  output logic [31:0]              ctl_mem_pc_o
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                     mem_ale_o
`endif
);

  ex2mem_t    in_bus;
  ex2mem_t    ex2mem_r;
  mem_state_e state;
  logic       valid_r;
  logic       mul_first_r;
  logic [31:0] result_r;
  logic [31:0] result;
  logic [31:0] addr;
  logic [31:0] load_data;
  logic       enter;
  logic       leave;
  logic       in_is_mem;
  logic       in_ale;
  logic       rd_we_eff;
  logic       unused_ok;

  assign in_bus        = ex2mem_t'(ex2mem_bus_i);
  assign mem_over_o    = valid_r & (state == S_DONE);
  assign leave         = mem_over_o & wb_allowin_i;
  assign mem_allowin_o = ~valid_r | leave;
  assign enter         = ex_over_i & mem_allowin_o;
  assign in_is_mem     = in_bus.mem_ctl.load | in_bus.mem_ctl.store;

`ifdef MEM_ALIGN_CHECK_EN
  logic ale_r;

  assign in_ale    = in_is_mem & misaligned(in_bus.mem_ctl.size, in_bus.exe_result[1:0]);
  assign addr      = ex2mem_r.exe_result;
  assign rd_we_eff = ex2mem_r.rd_we & ~ale_r;
  assign mem_ale_o = mem_over_o & ale_r;
`else
  assign in_ale    = 1'b0;
  assign rd_we_eff = ex2mem_r.rd_we;

  // Without the check, misaligned addresses silently round down to natural alignment.
  always_comb begin
    addr = ex2mem_r.exe_result;
    case (ex2mem_r.mem_ctl.size)
      SizeHalf: addr[0]   = 1'b0;
      SizeWord: addr[1:0] = 2'b00;
      default: ;
    endcase
  end
`endif

  mem_align u_align (
    .size      (ex2mem_r.mem_ctl.size),
    .bh_sign   (ex2mem_r.mem_ctl.bh_sign),
    .off       (addr[1:0]),
    .st_data   (ex2mem_r.st_data),
    .rdata     (dram_rdata_i),
    .wstrb     (dram_wstrb_o),
    .wdata     (dram_wdata_o),
    .load_data (load_data)
  );

  // The product is only valid in the first MEM cycle, so it is passed through
  // then and held in result_r afterwards.
  assign result = mul_first_r ? mult_product_i[31:0] : result_r;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      valid_r     <= 1'b0;
      mul_first_r <= 1'b0;
      ex2mem_r    <= '0;
      result_r    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      ale_r       <= 1'b0;
`endif
    end else if (enter) begin
      valid_r     <= 1'b1;
      ex2mem_r    <= in_bus;
      result_r    <= in_bus.exe_result;
      mul_first_r <= in_bus.multiply;
      state       <= (in_is_mem && !in_ale) ? S_REQ : S_DONE;
`ifdef MEM_ALIGN_CHECK_EN
      ale_r       <= in_ale;
`endif
    end else if (leave) begin
      valid_r     <= 1'b0;
      mul_first_r <= 1'b0;
      state       <= S_IDLE;
    end else begin
      case (state)
        S_REQ: begin
          if (dram_ack_i) begin
            state <= S_DONE;
            if (ex2mem_r.mem_ctl.load) result_r <= load_data;
          end
        end
        S_DONE: begin
          if (mul_first_r) begin
            result_r    <= mult_product_i[31:0];
            mul_first_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dram_req_o             = valid_r & (state == S_REQ);
  assign dram_we_o              = dram_req_o & ex2mem_r.mem_ctl.store;
  assign dram_addr_o            = addr;
  assign mem2wb_bus_o           = {ex2mem_r.rd_addr, rd_we_eff, result, ex2mem_r.pc};
  assign forward_mem2id_valid_o = valid_r & (~ex2mem_r.mem_ctl.load | (state == S_DONE));
  assign forward_mem2id_data_o  = valid_r ? result : 32'h0;
  assign ctl_mem_dest_o         = ex2mem_r.rd_addr & {5{valid_r}};
  assign ctl_mem_pc_o           = ex2mem_r.pc;

  assign unused_ok = ^{mult_product_i[63:32], ex2mem_r.multiply};

endmodule
